// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 register-access slave with auto-incrementing burst addressing
//
// Ports:
//   sclk      SPI serial clock, also the block clock (sample on rise, drive on fall)
//   rst       asynchronous active-high reset
//   cs_n      active-low chip select; high asynchronously aborts the frame
//   mosi      serial data in, MSB first
//   miso      serial data out, MSB first
//   miso_oe   MISO output enable (= ~cs_n)
//   ro_din    read-only slot values, slice i = [i*WIDTH +: WIDTH]
//   regs_q    writable register contents (RO slots tied 0)
//   wr_toggle bit i inverts on every accepted write to slot i
//   bad_addr  sticky flag: some frame addressed a non-existent slot
module spi_reg_slave #(
    parameter int                   WIDTH     = 8,
    parameter int                   NUM_REGS  = 16,
    parameter int                   ADDR_W    = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    input  logic [NUM_REGS*WIDTH-1:0] ro_din,
    output logic [NUM_REGS*WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]       wr_toggle,
    output logic                      bad_addr
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_CMD,
        ST_DATA
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WIDTH-1:0]    r_shift_in;
    logic [WIDTH-1:0]    r_shift_out;
    logic                r_rw;
    logic                r_illegal;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_miso;
    logic                r_bad_addr;

    logic [WIDTH-1:0]    w_word;
    logic                w_word_done;
    logic                w_cmd_legal;
    logic                w_wr_en;
    logic                w_load;
    logic [WIDTH-1:0]    w_rd_val;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_unused;

    // The word being completed includes the bit on mosi right now.
    assign w_word      = {r_shift_in[WIDTH-2:0], mosi};
    assign w_word_done = !cs_n && (r_bit_cnt == BIT_LAST);
    assign w_wr_en     = w_word_done && (r_state == ST_DATA) && !r_rw && !r_illegal;
    assign w_load      = (r_bit_cnt == '0) && (r_state == ST_DATA) && r_rw;
    assign w_addr_nxt  = (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);

    // NUM_REGS need not be a power of two, so legality is an explicit match.
    always_comb begin
        w_cmd_legal = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_word[ADDR_W-1:0] == ADDR_W'(i)) begin
                w_cmd_legal = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (!r_illegal) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_addr == ADDR_W'(i)) begin
                    w_rd_val = RO_MASK[i] ? ro_din[i*WIDTH +: WIDTH] : regs_q[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Frame state machine: cs_n high holds it in CMD.
    always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
        if (rst || cs_n) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_word_done && (r_state == ST_CMD)) begin
            w_state_nxt = ST_DATA;
        end
    end

    // Per-frame datapath, discarded on abort.
    always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
        if (rst || cs_n) begin
            r_bit_cnt  <= '0;
            r_shift_in <= '0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_shift_in <= w_word;
            if (w_word_done) begin
                r_bit_cnt <= '0;
                if (r_state == ST_CMD) begin
                    r_rw      <= w_word[WIDTH-1];
                    r_addr    <= w_word[ADDR_W-1:0];
                    r_illegal <= !w_cmd_legal;
                end else begin
                    r_addr <= w_addr_nxt;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // bad_addr survives aborts; only rst clears it.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_bad_addr <= 1'b0;
        end else if (w_word_done && (r_state == ST_CMD) && !w_cmd_legal) begin
            r_bad_addr <= 1'b1;
        end
    end

    // Output shifter on the falling edge: load at the first fall of each
    // read data word, otherwise shift. Bit WIDTH-1 goes straight to miso.
    always_ff @(negedge sclk or posedge rst or posedge cs_n) begin
        if (rst || cs_n) begin
            r_shift_out <= '0;
            r_miso      <= 1'b0;
        end else if (w_load) begin
            r_shift_out <= w_rd_val;
            r_miso      <= w_rd_val[WIDTH-1];
        end else begin
            r_shift_out <= {r_shift_out[WIDTH-2:0], 1'b0};
            r_miso      <= ((r_state == ST_DATA) && r_rw) ? r_shift_out[WIDTH-2] : 1'b0;
        end
    end

    // Register bank: RO slots have no storage at all.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
        if (RO_MASK[gi]) begin : g_ro
            assign regs_q[gi*WIDTH +: WIDTH] = '0;
            assign wr_toggle[gi]             = 1'b0;
        end else begin : g_rw
            logic [WIDTH-1:0] r_reg;
            logic             r_tog;

            always_ff @(posedge sclk or posedge rst) begin
                if (rst) begin
                    r_reg <= RESET_VAL;
                    r_tog <= 1'b0;
                end else if (w_wr_en && (r_addr == ADDR_W'(gi))) begin
                    r_reg <= w_word;
                    r_tog <= ~r_tog;
                end
            end

            assign regs_q[gi*WIDTH +: WIDTH] = r_reg;
            assign wr_toggle[gi]             = r_tog;
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = ~cs_n;
    assign bad_addr = r_bad_addr;

    // Writable-slot ro_din slices and the shifters' top bits are never read.
    assign w_unused = ^{ro_din, r_shift_in[WIDTH-1], r_shift_out[WIDTH-1]};

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - directed table-driven bench for spi_reg_slave
module tb_spi_reg_slave;

    logic         sclk = 1'b0;
    logic         rst  = 1'b1;
    logic         cs16 = 1'b1;
    logic         cs12 = 1'b1;
    logic         mosi = 1'b0;
    logic         miso16, oe16, bad16;
    logic         miso12, oe12, bad12;
    logic [127:0] q16;
    logic [95:0]  q12;
    logic [15:0]  tog16;
    logic [11:0]  tog12;
    logic [127:0] ro16 = {16{8'hEE}};
    logic [95:0]  ro12 = {{8{8'hEE}}, 8'h5A, {3{8'hEE}}};

    always #5 sclk = ~sclk;

    spi_reg_slave #(.WIDTH(8), .NUM_REGS(16)) dut16 (
        .sclk(sclk), .rst(rst), .cs_n(cs16), .mosi(mosi),
        .miso(miso16), .miso_oe(oe16), .ro_din(ro16),
        .regs_q(q16), .wr_toggle(tog16), .bad_addr(bad16)
    );

    spi_reg_slave #(.WIDTH(8), .NUM_REGS(12), .RO_MASK(12'h008)) dut12 (
        .sclk(sclk), .rst(rst), .cs_n(cs12), .mosi(mosi),
        .miso(miso12), .miso_oe(oe12), .ro_din(ro12),
        .regs_q(q12), .wr_toggle(tog12), .bad_addr(bad12)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered #1 after a falling edge; leaves #1 after a falling edge.
    task automatic shift_byte(input bit sel, input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int k = 0; k < nb; k++) begin
            r[7-k] = sel ? miso12 : miso16;
            mosi   = b[7-k];
            @(posedge sclk);
            @(negedge sclk);
            #1;
        end
    endtask

    task automatic frame(input bit sel, input int nbits, input logic [31:0] tx, output logic [31:0] rxv);
        logic [7:0] rb;
        int         nb;
        rxv = '0;
        @(negedge sclk);
        #1;
        if (sel) cs12 = 1'b0; else cs16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (nbits > i*8) begin
                nb = (nbits - i*8 > 8) ? 8 : nbits - i*8;
                shift_byte(sel, tx[31-8*i -: 8], nb, rb);
                rxv[31-8*i -: 8] = rb;
            end
        end
        cs12 = 1'b1;
        cs16 = 1'b1;
        mosi = 1'b0;
    endtask

    typedef struct {
        bit          sel;
        int          nbits;
        logic [31:0] tx;
        logic [31:0] exp_rx;
        int          reg_idx;
        logic [7:0]  exp_reg;
        logic [15:0] exp_tog;
        logic        exp_bad;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] rxv;
    logic [7:0]  rb;
    logic [7:0]  regv;
    logic [15:0] togv;
    logic        badv;

    initial begin
        // sel, nbits, tx, exp_rx, reg_idx, exp_reg, exp_tog, exp_bad
        vecs[0]  = '{0, 32, 32'h0EA1B2C3, 32'h00000000,  0, 8'hC3, 16'hC001, 1'b0};
        vecs[1]  = '{0, 24, 32'h8F000000, 32'h00B2C300, 15, 8'hB2, 16'hC001, 1'b0};
        vecs[2]  = '{0, 16, 32'h8E000000, 32'h00A10000, 14, 8'hA1, 16'hC001, 1'b0};
        vecs[3]  = '{0, 13, 32'h05FF0000, 32'h00000000,  5, 8'h00, 16'hC001, 1'b0};
        vecs[4]  = '{0, 16, 32'h013C0000, 32'h00000000,  1, 8'h3C, 16'hC003, 1'b0};
        vecs[5]  = '{0, 24, 32'h80000000, 32'h00C33C00,  1, 8'h3C, 16'hC003, 1'b0};
        vecs[6]  = '{1, 16, 32'h03FF0000, 32'h00000000,  3, 8'h00, 16'h0000, 1'b0};
        vecs[7]  = '{1, 16, 32'h83000000, 32'h005A0000,  3, 8'h00, 16'h0000, 1'b0};
        vecs[8]  = '{1, 16, 32'h0D770000, 32'h00000000,  1, 8'h00, 16'h0000, 1'b1};
        vecs[9]  = '{1, 16, 32'h8D000000, 32'h00000000,  1, 8'h00, 16'h0000, 1'b1};
        vecs[10] = '{1, 24, 32'h0B112200, 32'h00000000,  0, 8'h22, 16'h0801, 1'b1};
        vecs[11] = '{1, 24, 32'h8B000000, 32'h00112200, 11, 8'h11, 16'h0801, 1'b1};
        vecs[12] = '{1,  8, 32'h05000000, 32'h00000000,  5, 8'h00, 16'h0801, 1'b1};

        repeat (3) @(negedge sclk);
        #1;
        rst = 1'b0;
        check("reset_q16",   q16[31:0] | q16[63:32] | q16[95:64] | q16[127:96], 32'h0);
        check("reset_q12",   q12[31:0] | q12[63:32] | q12[95:64], 32'h0);
        check("reset_tog16", {16'h0, tog16}, 32'h0);
        check("reset_tog12", {20'h0, tog12}, 32'h0);
        check("reset_bad",   {30'h0, bad16, bad12}, 32'h0);
        check("reset_miso",  {30'h0, miso16, miso12}, 32'h0);
        check("reset_oe",    {30'h0, oe16, oe12}, 32'h0);

        for (int v = 0; v < 13; v++) begin
            frame(vecs[v].sel, vecs[v].nbits, vecs[v].tx, rxv);
            regv = vecs[v].sel ? q12[vecs[v].reg_idx*8 +: 8] : q16[vecs[v].reg_idx*8 +: 8];
            togv = vecs[v].sel ? {4'h0, tog12} : tog16;
            badv = vecs[v].sel ? bad12 : bad16;
            check($sformatf("v%0d_rx", v),  rxv, vecs[v].exp_rx);
            check($sformatf("v%0d_reg", v), {24'h0, regv}, {24'h0, vecs[v].exp_reg});
            check($sformatf("v%0d_tog", v), {16'h0, togv}, {16'h0, vecs[v].exp_tog});
            check($sformatf("v%0d_bad", v), {31'h0, badv}, {31'h0, vecs[v].exp_bad});
        end

        check("burst_reg14", {24'h0, q16[14*8 +: 8]}, 32'hA1);
        check("burst_reg15", {24'h0, q16[15*8 +: 8]}, 32'hB2);

        // rst clears the sticky flag and the bank
        @(negedge sclk);
        #1;
        rst = 1'b1;
        @(negedge sclk);
        #1;
        rst = 1'b0;
        check("rst2_bad12", {31'h0, bad12}, 32'h0);
        check("rst2_tog12", {20'h0, tog12}, 32'h0);
        check("rst2_reg0",  {24'h0, q12[7:0]}, 32'h0);

        // rst mid-frame with cs_n held low: next rise starts a fresh command
        cs12 = 1'b0;
        shift_byte(1'b1, 8'hFF, 3, rb);
        rst = 1'b1;
        @(negedge sclk);
        #1;
        check("midrst_oe", {31'h0, oe12}, 32'h1);
        rst = 1'b0;
        shift_byte(1'b1, 8'h02, 8, rb);
        shift_byte(1'b1, 8'h66, 8, rb);
        cs12 = 1'b1;
        mosi = 1'b0;
        check("midrst_reg2", {24'h0, q12[2*8 +: 8]}, 32'h66);
        check("midrst_tog",  {20'h0, tog12}, 32'h004);
        check("midrst_bad",  {31'h0, bad12}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
